ds1302_multi_reg_seq: RTL and testbench

//  Parametrised multi-register sequencer for DS1302: moves N_REGS consecutive byte registers
//  (clock block or RAM) between a packed user vector and the DS1302 single-byte transfer layer.

---
 rtl/ds1302_multi_reg_seq.sv | 196 +++++++++++++++++++
 tb/tb_ds1302_multi_reg_seq.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ds1302_multi_reg_seq.sv
// DS1302 multi-register sequencer: N_REGS byte transfers per transaction, auto-poll, ack timeout.
// Optional macro DS1302_WP_RESTORE_EN re-enables write-protect (8E <- 80) after each write burst.
module ds1302_multi_reg_seq #(
    parameter int unsigned N_REGS      = 7,
    parameter logic [7:0]  BASE_ADDR   = 8'h80,
    parameter int unsigned POLL_DIV    = 1000000,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                  ds1302_clk,
    input  logic                  ds1302_rst,
    input  logic                  wr_req,
    input  logic [8*N_REGS-1:0]   wr_data,
    output logic                  wr_ack,
    input  logic                  rd_req,
    input  logic                  poll_en,
    output logic [8*N_REGS-1:0]   rd_data,
    output logic                  rd_ack,
    output logic                  busy,
    output logic                  timeout_err,
    output logic                  byte_wr_en,
    output logic [7:0]            byte_wr_addr,
    output logic [7:0]            byte_wr_data,
    input  logic                  byte_wr_ack,
    output logic                  byte_rd_en,
    output logic [7:0]            byte_rd_addr,
    input  logic [7:0]            byte_rd_data,
    input  logic                  byte_rd_ack
);

    localparam int unsigned IW = $clog2(N_REGS) + 1;
    localparam int unsigned PW = $clog2(POLL_DIV) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WP_CLR  = 3'd1;
    localparam logic [2:0] S_WR_BYTE = 3'd2;
    localparam logic [2:0] S_WP_SET  = 3'd3;
    localparam logic [2:0] S_RD_BYTE = 3'd4;
    localparam logic [2:0] S_DONE_WR = 3'd5;
    localparam logic [2:0] S_DONE_RD = 3'd6;

    logic [2:0]          r_state;
    logic [IW-1:0]       r_idx;
    logic                r_en;
    logic [TW-1:0]       r_to_cnt;
    logic [PW-1:0]       r_poll_cnt;
    logic                r_poll_pend;
    logic [8*N_REGS-1:0] r_shadow;
    logic [8*N_REGS-1:0] r_rd_data;
    logic                r_timeout_err;

    logic                w_wr_state;
    logic                w_rd_state;
    logic                w_ack;
    logic                w_timeout;
    logic                w_poll_wrap;
    logic [7:0]          w_idx8;
    logic [7:0]          w_reg_addr;
    logic [7:0]          w_wr_byte;
    logic [8*N_REGS-1:0] w_shadow_next;

    assign w_wr_state  = (r_state == S_WP_CLR) || (r_state == S_WR_BYTE) || (r_state == S_WP_SET);
    assign w_rd_state  = (r_state == S_RD_BYTE);
    assign w_ack       = r_en && ((w_wr_state && byte_wr_ack) || (w_rd_state && byte_rd_ack));
    assign w_timeout   = r_en && !w_ack && (r_to_cnt == TW'(TIMEOUT_CYC - 1));
    assign w_poll_wrap = poll_en && (r_poll_cnt == PW'(POLL_DIV - 1));
    assign w_idx8      = 8'(r_idx);
    assign w_reg_addr  = BASE_ADDR + (w_idx8 << 1);

    always_comb begin
        w_wr_byte     = '0;
        w_shadow_next = r_shadow;
        for (int unsigned i = 0; i < N_REGS; i++) begin
            if (r_idx == IW'(i)) begin
                w_wr_byte                = wr_data[8*i +: 8];
                w_shadow_next[8*i +: 8]  = byte_rd_data;
            end
        end
    end

    always_comb begin
        byte_wr_addr = '0;
        byte_wr_data = '0;
        byte_rd_addr = '0;
        case (r_state)
            S_WP_CLR: begin
                byte_wr_addr = 8'h8E;
                byte_wr_data = 8'h00;
            end
            S_WR_BYTE: begin
                byte_wr_addr = w_reg_addr;
                byte_wr_data = w_wr_byte;
            end
            S_WP_SET: begin
                byte_wr_addr = 8'h8E;
                byte_wr_data = 8'h80;
            end
            S_RD_BYTE: byte_rd_addr = w_reg_addr + 8'd1;
            default: ;
        endcase
    end

    assign byte_wr_en  = r_en && w_wr_state;
    assign byte_rd_en  = r_en && w_rd_state;
    assign busy        = (r_state != S_IDLE);
    assign wr_ack      = (r_state == S_DONE_WR);
    assign rd_ack      = (r_state == S_DONE_RD);
    assign rd_data     = r_rd_data;
    assign timeout_err = r_timeout_err;

    always_ff @(posedge ds1302_clk) begin
        if (ds1302_rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_en          <= 1'b0;
            r_to_cnt      <= '0;
            r_poll_cnt    <= '0;
            r_poll_pend   <= 1'b0;
            r_shadow      <= '0;
            r_rd_data     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;

            if (!poll_en) begin
                r_poll_cnt  <= '0;
                r_poll_pend <= 1'b0;
            end else if (w_poll_wrap) begin
                r_poll_cnt  <= '0;
                r_poll_pend <= 1'b1;
            end else begin
                r_poll_cnt  <= r_poll_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (wr_req) begin
                        r_state <= S_WP_CLR;
                    end else if (rd_req) begin
                        r_state <= S_RD_BYTE;
                        r_idx   <= IW'(N_REGS - 1);
                    end else if (r_poll_pend) begin
                        r_state <= S_RD_BYTE;
                        r_idx   <= IW'(N_REGS - 1);
                        // a wrap in this same cycle re-arms the next poll
                        if (!w_poll_wrap) r_poll_pend <= 1'b0;
                    end
                end
                S_WP_CLR, S_WR_BYTE, S_WP_SET, S_RD_BYTE: begin
                    if (!r_en) begin
                        r_en     <= 1'b1;
                        r_to_cnt <= '0;
                    end else if (w_ack) begin
                        r_en <= 1'b0;
                        case (r_state)
                            S_WP_CLR: begin
                                r_state <= S_WR_BYTE;
                                r_idx   <= IW'(N_REGS - 1);
                            end
                            S_WR_BYTE: begin
                                if (r_idx == '0) begin
`ifdef DS1302_WP_RESTORE_EN
                                    r_state <= S_WP_SET;
`else
                                    r_state <= S_DONE_WR;
`endif
                                end else begin
                                    r_idx <= r_idx - 1'b1;
                                end
                            end
                            S_WP_SET: r_state <= S_DONE_WR;
                            default: begin
                                r_shadow <= w_shadow_next;
                                // commit on the final byte so rd_data is already valid while rd_ack is high
                                if (r_idx == '0) begin
                                    r_rd_data <= w_shadow_next;
                                    r_state   <= S_DONE_RD;
                                end else begin
                                    r_idx <= r_idx - 1'b1;
                                end
                            end
                        endcase
                    end else if (w_timeout) begin
                        r_en          <= 1'b0;
                        r_state       <= S_IDLE;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ds1302_multi_reg_seq.sv
// Scoreboard bench for ds1302_multi_reg_seq: converter model acks 3 cycles after en.
// Expected writes include the extra (8E,80) when DS1302_WP_RESTORE_EN is defined.
module tb_ds1302_multi_reg_seq;

    localparam int NR = 7;
    localparam int K_BW = 0, K_BR = 1, K_WACK = 2, K_RACK = 3, K_TERR = 4;

    typedef struct {
        int          kind;
        logic [7:0]  a;
        logic [7:0]  d;
        logic [55:0] v;
    } ev_t;

    logic        clk, rst;
    logic        wr_req, rd_req, poll_en;
    logic [55:0] wr_data, rd_data;
    logic        wr_ack, rd_ack, busy, timeout_err;
    logic        byte_wr_en, byte_wr_ack, byte_rd_en, byte_rd_ack;
    logic [7:0]  byte_wr_addr, byte_wr_data, byte_rd_addr, byte_rd_data;

    ev_t         exp_q[$];
    int          n_vec, n_err, cyc;
    logic [7:0]  rd_mem [256];
    logic [7:0]  stall_addr;

    ds1302_multi_reg_seq #(
        .N_REGS(NR), .BASE_ADDR(8'h80), .POLL_DIV(50), .TIMEOUT_CYC(20)
    ) dut (
        .ds1302_clk(clk), .ds1302_rst(rst),
        .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .poll_en(poll_en), .rd_data(rd_data), .rd_ack(rd_ack),
        .busy(busy), .timeout_err(timeout_err),
        .byte_wr_en(byte_wr_en), .byte_wr_addr(byte_wr_addr), .byte_wr_data(byte_wr_data),
        .byte_wr_ack(byte_wr_ack),
        .byte_rd_en(byte_rd_en), .byte_rd_addr(byte_rd_addr), .byte_rd_data(byte_rd_data),
        .byte_rd_ack(byte_rd_ack)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [7:0] a, input logic [7:0] d, input logic [55:0] v);
        ev_t e;
        e.kind = k; e.a = a; e.d = d; e.v = v;
        exp_q.push_back(e);
    endtask

    task automatic push_write(input logic [55:0] v);
        push(K_BW, 8'h8E, 8'h00, '0);
        for (int i = NR - 1; i >= 0; i--) push(K_BW, 8'(8'h80 + 2 * i), v[8*i +: 8], '0);
`ifdef DS1302_WP_RESTORE_EN
        push(K_BW, 8'h8E, 8'h80, '0);
`endif
        push(K_WACK, 0, 0, '0);
    endtask

    task automatic push_read(input logic [55:0] v);
        for (int i = NR - 1; i >= 0; i--) push(K_BR, 8'(8'h81 + 2 * i), 0, '0);
        push(K_RACK, 0, 0, v);
    endtask

    task automatic got(input string nm, input int k, input logic [7:0] a, input logic [7:0] d,
                       input logic [55:0] v);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: unexpected event a=%0h d=%0h v=%0h, none required", nm, a, d, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.a !== a || e.d !== d || e.v !== v) begin
                n_err++;
                $display("FAIL %s: got kind=%0d a=%0h d=%0h v=%0h required kind=%0d a=%0h d=%0h v=%0h",
                         nm, k, a, d, v, e.kind, e.a, e.d, e.v);
            end
        end
    endtask

    // converter model, write side
    initial begin : wr_model
        int n;
        n = 0;
        byte_wr_ack = 0;
        forever begin
            @(negedge clk);
            if (byte_wr_en && !byte_wr_ack) begin
                n++;
                if (n == 3) begin byte_wr_ack = 1; n = 0; end
            end else begin
                byte_wr_ack = 0;
                n = 0;
            end
        end
    end

    // converter model, read side; never acks stall_addr
    initial begin : rd_model
        int n;
        n = 0;
        byte_rd_ack = 0;
        byte_rd_data = 0;
        forever begin
            @(negedge clk);
            if (byte_rd_en && !byte_rd_ack) begin
                if (byte_rd_addr != stall_addr) n++;
                if (n == 3) begin
                    byte_rd_ack  = 1;
                    byte_rd_data = rd_mem[byte_rd_addr];
                    n = 0;
                end
            end else begin
                byte_rd_ack = 0;
                n = 0;
            end
        end
    end

    initial begin : monitor
        int  last_ack_cyc, rd_rise;
        bit  prev_ack, prev_rd_en, ack_now;
        last_ack_cyc = -10; rd_rise = -100; prev_ack = 0; prev_rd_en = 0;
        forever begin
            @(negedge clk);
            #1;
            ack_now = 0;
            if (prev_ack) chk("en_gap", {63'd0, byte_wr_en | byte_rd_en}, 0);
            if (byte_rd_en && !prev_rd_en) rd_rise = cyc;
            prev_rd_en = byte_rd_en;
            if (byte_wr_en && byte_wr_ack) begin
                got("byte_write", K_BW, byte_wr_addr, byte_wr_data, '0);
                ack_now = 1;
            end
            if (byte_rd_en && byte_rd_ack) begin
                got("byte_read", K_BR, byte_rd_addr, 0, '0);
                ack_now = 1;
            end
            if (ack_now) last_ack_cyc = cyc;
            if (wr_ack) begin
                got("wr_ack", K_WACK, 0, 0, '0);
                chk("wr_ack_latency", 64'(cyc - last_ack_cyc), 1);
            end
            if (rd_ack) begin
                got("rd_ack", K_RACK, 0, 0, rd_data);
                chk("rd_ack_latency", 64'(cyc - last_ack_cyc), 1);
            end
            if (timeout_err) begin
                got("timeout_err", K_TERR, 0, 0, '0);
                chk("timeout_latency", 64'(cyc - rd_rise), 20);
            end
            prev_ack = ack_now;
        end
    end

    task automatic wait_idle(input string nm);
        int i;
        i = 0;
        @(negedge clk);
        while (busy && i < 400) begin
            @(negedge clk);
            i++;
        end
        chk(nm, {63'd0, busy}, 0);
    endtask

    task automatic start(input bit w, input bit r, input string nm);
        @(negedge clk);
        wr_req = w;
        rd_req = r;
        @(negedge clk);
        wr_req = 0;
        rd_req = 0;
        chk(nm, {63'd0, busy}, 1);
    endtask

    initial begin : stim
        logic [55:0] v1, v2, pv;
        int          s[3];
        int          starts, t0, rises, i;
        bit          pb;
        n_vec = 0; n_err = 0;
        rst = 1; wr_req = 0; rd_req = 0; poll_en = 0; wr_data = '0;
        stall_addr = 8'h00;
        for (int a = 0; a < 256; a++) rd_mem[a] = 8'h00;
        v1 = 56'h24_01_05_15_12_30_00;
        v2 = 56'h11_22_33_44_55_66_77;

        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 0);
        chk("rst_wr_en", {63'd0, byte_wr_en}, 0);
        chk("rst_rd_en", {63'd0, byte_rd_en}, 0);
        chk("rst_rd_data", {8'd0, rd_data}, 0);
        chk("rst_acks", {61'd0, wr_ack, rd_ack, timeout_err}, 0);
        chk("rst_wr_addr", {56'd0, byte_wr_addr}, 0);

        // basic write
        wr_data = v1;
        push_write(v1);
        start(1, 0, "wr_busy_latency");
        wait_idle("wr_done");

        // basic read
        rd_mem[8'h8D] = 8'h24; rd_mem[8'h8B] = 8'h01; rd_mem[8'h89] = 8'h05;
        rd_mem[8'h87] = 8'h15; rd_mem[8'h85] = 8'h12; rd_mem[8'h83] = 8'h30;
        rd_mem[8'h81] = 8'h45;
        push_read(56'h24_01_05_15_12_30_45);
        start(0, 1, "rd_busy_latency");
        wait_idle("rd_done");
        chk("rd_data_hold", {8'd0, rd_data}, 64'h24_01_05_15_12_30_45);

        // simultaneous one-cycle requests: write only
        wr_data = v2;
        push_write(v2);
        start(1, 1, "both_busy");
        wait_idle("both_done");
        repeat (3) @(negedge clk);
        chk("both_no_read", {63'd0, busy}, 0);

        // rd_req held through write: read follows
        push_write(v2);
        push_read(56'h24_01_05_15_12_30_45);
        @(negedge clk);
        wr_req = 1; rd_req = 1;
        @(negedge clk);
        wr_req = 0;
        i = 0;
        while (!wr_ack && i < 200) begin @(negedge clk); i++; end
        chk("held_wr_ack_seen", {63'd0, wr_ack}, 1);
        @(negedge clk);
        chk("held_idle_gap", {63'd0, busy}, 0);
        @(negedge clk);
        rd_req = 0;
        chk("held_read_started", {63'd0, busy}, 1);
        wait_idle("held_done");

        // auto-poll
        for (int a = 0; a < 256; a++) rd_mem[a] = 8'(a) ^ 8'h5A;
        for (int k = 0; k < NR; k++) pv[8*k +: 8] = 8'(8'h81 + 2 * k) ^ 8'h5A;
        repeat (3) push_read(pv);
        @(negedge clk);
        poll_en = 1;
        t0 = cyc;
        starts = 0; pb = 0; i = 0;
        while (starts < 3 && i < 400) begin
            @(negedge clk);
            if (busy && !pb) begin s[starts] = cyc; starts++; end
            pb = busy;
            i++;
        end
        poll_en = 0;
        chk("poll_count", 64'(starts), 3);
        chk("poll_first", 64'(s[0] - t0), 51);
        chk("poll_period1", 64'(s[1] - s[0]), 50);
        chk("poll_period2", 64'(s[2] - s[1]), 50);
        wait_idle("poll_done");
        rises = 0; pb = 0;
        repeat (120) begin
            @(negedge clk);
            if (busy && !pb) rises++;
            pb = busy;
        end
        chk("poll_off", 64'(rises), 0);

        // timeout on third read byte
        stall_addr = 8'h89;
        push(K_BR, 8'h8D, 0, '0);
        push(K_BR, 8'h8B, 0, '0);
        push(K_TERR, 0, 0, '0);
        start(0, 1, "to_busy");
        wait_idle("to_done");
        chk("to_rd_data", {8'd0, rd_data}, {8'd0, pv});
        stall_addr = 8'h00;

        // reset during WR_BYTE, then restart
        wr_data = v1;
        push(K_BW, 8'h8E, 8'h00, '0);
        push(K_BW, 8'h8C, 8'h24, '0);
        start(1, 0, "mid_busy");
        i = 0;
        while (!(byte_wr_en && byte_wr_addr == 8'h8A) && i < 200) begin @(negedge clk); i++; end
        chk("mid_reached", {63'd0, byte_wr_en}, 1);
        rst = 1;
        @(negedge clk);
        chk("mid_wr_en", {63'd0, byte_wr_en}, 0);
        chk("mid_busy_low", {63'd0, busy}, 0);
        chk("mid_no_ack", {63'd0, wr_ack}, 0);
        rst = 0;
        repeat (3) @(negedge clk);
        push_write(v1);
        start(1, 0, "restart_busy");
        wait_idle("restart_done");

        repeat (5) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
